jk_edge_monitor: RTL and testbench
==================================

Name: jk_edge_monitor

Overview:
Downstream observer for the synchronous JK flip-flop stage. Samples the flip-flop's q output in the same clock domain and classifies it as low, high or stuck. Counts rising and falling transitions, records the length of the last completed run, and flags a stuck output after a programmable timeout. Used as a self-check and status source beside the JK stage.

Parameters:
- CNT_W, 8: width of the edge counters, run-length output and internal run counter.
- TIMEOUT, 16: number of consecutive equal samples that declares stuck. Legal range 2 to 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock, shared with the JK stage.
- reset  in  1  asynchronous, active-low reset.
- q  in  1  JK flip-flop output, synchronous to clk.
- clr  in  1  synchronous clear of counters and run_len, active-high.
- rise_pulse  out  1  one-cycle pulse per accepted 0->1 transition.
- fall_pulse  out  1  one-cycle pulse per accepted 1->0 transition.
- rise_cnt  out  CNT_W  saturating count of rising transitions.
- fall_cnt  out  CNT_W  saturating count of falling transitions.
- run_len  out  CNT_W  sample length of the last completed run.
- stuck  out  1  high while the current run has reached TIMEOUT.
- state  out  2  FSM state: INIT=00, LOW=01, HIGH=10, STUCK=11.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - state=INIT; all outputs 0; internal run counter 0; stuck level register 0.
- All outputs are registered. Updates take effect at the posedge that samples q.
- INIT: the first posedge after reset release samples q and moves to LOW (q=0) or HIGH (q=1). Run counter is set to 1. No pulse and no count are produced.
- LOW / HIGH, q equals the current level:
  - run counter increments, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT: state goes to STUCK and stuck=1 at the same edge. The stuck level is remembered.
- LOW / HIGH / STUCK, q differs from the current level:
  - the matching pulse is 1 for exactly the following cycle;
  - the matching counter increments, saturating at 2^CNT_W-1;
  - run_len takes the finished run count;
  - run counter is set to 1; state goes to the new level; stuck=0.
- STUCK holds while q equals the stuck level. The run counter stays at TIMEOUT.
- Pulses are 0 in every cycle without an accepted transition. rise_pulse and fall_pulse are never 1 together.
- clr=1 sets rise_cnt, fall_cnt and run_len to 0 at the same edge. It does not change state, stuck, the run counter or the pulses.
  - clr has priority over an increment at the same edge. The counter ends at 0, but the pulse is still issued.
- Reset asserted mid-run forces INIT immediately, regardless of clk.

Optional Feature:
- Macro JK_MON_GLITCH_FILTER_EN.
- Defined: a level change is accepted only after q differs from the current level on 2 consecutive samples. This adds one cycle of pulse and count latency. A 1-sample excursion is ignored: no pulse, no count, and the run counter keeps counting.
- Undefined: a single differing sample is accepted, as described in Behaviour.

Test Plan:
- Hold q=0 through reset release for 5 sampled edges -> state=01 after the first edge; all counts 0; no pulses; stuck=0.
- Continue from the previous case, then q=1 -> rise_pulse high for 1 cycle; rise_cnt=1; run_len=5; state=10.
- Hold q=1 for 16 edges with TIMEOUT=16 -> stuck=1 and state=11 at the 16th edge. Then q=0 -> fall_pulse; fall_cnt=1; run_len=16; stuck=0; state=01.
- Toggle q every cycle for 300 rising edges with CNT_W=8 -> rise_cnt and fall_cnt hold at 255; run_len=1.
- Assert clr on the same edge as a rising transition -> rise_pulse=1; rise_cnt=0; run_len=0; state=10.
- Drop reset mid-run with clk stopped -> all outputs 0 and state=00 immediately.
- With JK_MON_GLITCH_FILTER_EN, a 1-cycle q high glitch -> no rise_pulse and rise_cnt unchanged. A 2-cycle high -> rise_pulse one cycle later than in the unfiltered build.

Source files
------------

// File: rtl/jk_edge_monitor_if.sv
// ---------------------------------------------------------------------------
// jk_edge_monitor_if
// Signal bundle between the JK flip-flop stage (master side: drives q and
// clr) and the jk_edge_monitor observer (slave side: drives the status).
//   q          : JK flip-flop output, synchronous to clk
//   clr        : synchronous clear of counters and run_len, active-high
//   rise_pulse : one-cycle pulse per accepted 0->1 transition
//   fall_pulse : one-cycle pulse per accepted 1->0 transition
//   rise_cnt   : saturating rising-transition count
//   fall_cnt   : saturating falling-transition count
//   run_len    : sample length of the last completed run
//   stuck      : current run has reached the timeout
//   state      : INIT=00, LOW=01, HIGH=10, STUCK=11
// ---------------------------------------------------------------------------
interface jk_edge_monitor_if #(
    parameter int CNT_W = 8
);
    logic             q;
    logic             clr;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] run_len;
    logic             stuck;
    logic [1:0]       state;

    modport master (
        output q, clr,
        input  rise_pulse, fall_pulse, rise_cnt, fall_cnt, run_len, stuck, state
    );

    modport slave (
        input  q, clr,
        output rise_pulse, fall_pulse, rise_cnt, fall_cnt, run_len, stuck, state
    );
endinterface

// File: rtl/jk_edge_monitor.sv
// ---------------------------------------------------------------------------
// jk_edge_monitor
// Observer for the synchronous JK flip-flop stage. Classifies the sampled q
// as LOW, HIGH or STUCK, counts rising/falling transitions (saturating),
// records the length of the last completed run and flags a stuck output
// after TIMEOUT consecutive equal samples.
//
// Ports:
//   clk   : rising-edge clock shared with the JK stage
//   reset : asynchronous active-low reset
//   mon   : jk_edge_monitor_if.slave (q, clr in; pulses, counts, run_len,
//           stuck, state out). All outputs are registered.
//
// Parameters:
//   CNT_W   : width of edge counters, run_len and the internal run counter
//   TIMEOUT : consecutive equal samples that declare stuck (2..2^CNT_W-1)
//
// Build option:
//   JK_MON_GLITCH_FILTER_EN : when defined, a level change is accepted only
//   after q differs from the current level on two consecutive samples.
// ---------------------------------------------------------------------------
module jk_edge_monitor #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    jk_edge_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_LOW   = 2'b01,
        ST_HIGH  = 2'b10,
        ST_STUCK = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] rise_cnt_q;
    logic [CNT_W-1:0] fall_cnt_q;
    logic [CNT_W-1:0] run_len_q;
    logic             rise_q;
    logic             fall_q;
    logic             stuck_q;
    logic             stuck_lvl_q;
    logic             pend_q;

    logic             cur_lvl_d;
    logic             differ_d;
    logic             accept_d;
    logic             pend_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + ONE;
    endfunction

    // Level the monitor currently believes q is at; in STUCK it is the level
    // remembered when the timeout fired.
    always_comb begin
        cur_lvl_d = 1'b0;
        case (state_q)
            ST_HIGH:  cur_lvl_d = 1'b1;
            ST_STUCK: cur_lvl_d = stuck_lvl_q;
            default:  cur_lvl_d = 1'b0;
        endcase
        differ_d = (state_q != ST_INIT) && (mon.q != cur_lvl_d);
`ifdef JK_MON_GLITCH_FILTER_EN
        // The first differing sample only arms pend_q; the second accepts.
        accept_d = differ_d && pend_q;
        pend_d   = differ_d && !pend_q;
`else
        accept_d = differ_d;
        pend_d   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            run_q       <= '0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            run_len_q   <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pend_q <= pend_d;

            if (state_q == ST_INIT) begin
                state_q <= mon.q ? ST_HIGH : ST_LOW;
                run_q   <= ONE;
            end else if (accept_d) begin
                if (mon.q) begin
                    rise_q     <= 1'b1;
                    rise_cnt_q <= sat_inc(rise_cnt_q);
                end else begin
                    fall_q     <= 1'b1;
                    fall_cnt_q <= sat_inc(fall_cnt_q);
                end
                run_len_q <= run_q;
                run_q     <= ONE;
                state_q   <= mon.q ? ST_HIGH : ST_LOW;
                stuck_q   <= 1'b0;
            end else if (state_q != ST_STUCK) begin
                // Same level (or a filtered one-sample excursion): the run
                // keeps growing until it reaches the timeout.
                if (run_q == TO_M1) begin
                    run_q       <= TO_VAL;
                    state_q     <= ST_STUCK;
                    stuck_q     <= 1'b1;
                    stuck_lvl_q <= cur_lvl_d;
                end else begin
                    run_q <= run_q + ONE;
                end
            end

            // Clear wins over any increment at the same edge; pulses and
            // FSM state are left as computed above.
            if (mon.clr) begin
                rise_cnt_q <= '0;
                fall_cnt_q <= '0;
                run_len_q  <= '0;
            end
        end
    end

    assign mon.rise_pulse = rise_q;
    assign mon.fall_pulse = fall_q;
    assign mon.rise_cnt   = rise_cnt_q;
    assign mon.fall_cnt   = fall_cnt_q;
    assign mon.run_len    = run_len_q;
    assign mon.stuck      = stuck_q;
    assign mon.state      = state_q;

endmodule

// File: tb/tb_jk_edge_monitor.sv
module tb_jk_edge_monitor;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic reset  = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    jk_edge_monitor_if #(.CNT_W(CNT_W)) bus ();

    jk_edge_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus.slave)
    );

    always #5 if (clk_en) clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.q   = 1'b0;
        bus.clr = 1'b0;

        // Reset state, checked between edges while reset is held.
        #12;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_rise_cnt", 32'(bus.rise_cnt), 0);
        chk("rst_run_len", 32'(bus.run_len), 0);
        chk("rst_stuck", 32'(bus.stuck), 0);
        chk("rst_pulses", 32'({bus.rise_pulse, bus.fall_pulse}), 0);
        reset = 1'b1;

        // Hold q=0 for 5 sampled edges.
        tick();
        chk("init_to_low", 32'(bus.state), 1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("low_no_pulse", 32'({bus.rise_pulse, bus.fall_pulse}), 0);
        end
        chk("low_state", 32'(bus.state), 1);
        chk("low_counts", 32'({bus.rise_cnt, bus.fall_cnt}), 0);
        chk("low_stuck", 32'(bus.stuck), 0);

`ifdef JK_MON_GLITCH_FILTER_EN
        // One-sample high glitch is ignored.
        bus.q = 1'b1; tick();
        chk("glitch_s1_pulse", 32'(bus.rise_pulse), 0);
        bus.q = 1'b0; tick();
        chk("glitch_s2_pulse", 32'(bus.rise_pulse), 0);
        chk("glitch_rise_cnt", 32'(bus.rise_cnt), 0);
        chk("glitch_state", 32'(bus.state), 1);
        // Two-sample high: accepted on the second sample.
        bus.q = 1'b1; tick();
        chk("filt_first_pulse", 32'(bus.rise_pulse), 0);
        chk("filt_first_state", 32'(bus.state), 1);
        tick();
        chk("filt_rise_pulse", 32'(bus.rise_pulse), 1);
        chk("filt_rise_cnt", 32'(bus.rise_cnt), 1);
        chk("filt_state", 32'(bus.state), 2);
        // Run kept counting through the glitch: 5 + 1 + 1 + 1 samples.
        chk("filt_run_len", 32'(bus.run_len), 8);
        tick();
        chk("filt_pulse_gone", 32'(bus.rise_pulse), 0);
`else
        // Rising transition.
        bus.q = 1'b1; tick();
        chk("rise_pulse", 32'(bus.rise_pulse), 1);
        chk("rise_cnt", 32'(bus.rise_cnt), 1);
        chk("rise_run_len", 32'(bus.run_len), 5);
        chk("rise_state", 32'(bus.state), 2);
        tick();
        chk("rise_pulse_gone", 32'(bus.rise_pulse), 0);

        // Stuck after 16 high samples (transition edge is sample 1).
        for (int i = 3; i <= 15; i++) tick();
        chk("pre_stuck", 32'(bus.stuck), 0);
        chk("pre_stuck_state", 32'(bus.state), 2);
        tick();
        chk("stuck_flag", 32'(bus.stuck), 1);
        chk("stuck_state", 32'(bus.state), 3);
        tick();
        chk("stuck_hold", 32'(bus.state), 3);

        // Leave STUCK with a falling transition.
        bus.q = 1'b0; tick();
        chk("fall_pulse", 32'(bus.fall_pulse), 1);
        chk("fall_no_rise", 32'(bus.rise_pulse), 0);
        chk("fall_cnt", 32'(bus.fall_cnt), 1);
        chk("fall_run_len", 32'(bus.run_len), 16);
        chk("fall_stuck", 32'(bus.stuck), 0);
        chk("fall_state", 32'(bus.state), 1);

        // clr on the same edge as a rising transition.
        bus.q = 1'b1; bus.clr = 1'b1; tick();
        bus.clr = 1'b0;
        chk("clr_rise_pulse", 32'(bus.rise_pulse), 1);
        chk("clr_rise_cnt", 32'(bus.rise_cnt), 0);
        chk("clr_fall_cnt", 32'(bus.fall_cnt), 0);
        chk("clr_run_len", 32'(bus.run_len), 0);
        chk("clr_state", 32'(bus.state), 2);

        // Toggle every cycle: 300 falls and 300 rises saturate at 255.
        for (int i = 0; i < 300; i++) begin
            bus.q = 1'b0; tick();
            bus.q = 1'b1; tick();
        end
        chk("sat_rise_cnt", 32'(bus.rise_cnt), 255);
        chk("sat_fall_cnt", 32'(bus.fall_cnt), 255);
        chk("sat_run_len", 32'(bus.run_len), 1);
        chk("sat_rise_pulse", 32'(bus.rise_pulse), 1);
`endif

        // Asynchronous reset with the clock stopped.
        clk_en = 1'b0;
        #20;
        reset = 1'b0;
        #1;
        chk("async_state", 32'(bus.state), 0);
        chk("async_counts", 32'({bus.rise_cnt, bus.fall_cnt}), 0);
        chk("async_pulses", 32'({bus.rise_pulse, bus.fall_pulse}), 0);
        chk("async_run_len", 32'(bus.run_len), 0);
        chk("async_stuck", 32'(bus.stuck), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
